// File: rtl/multi_pulse_stretcher_pkg.sv
// Shared definitions for the multi-channel pulse stretcher: edge-select
// encoding, default counter width and the edge-to-trigger selector.
package multi_pulse_stretcher_pkg;

    localparam int DEFAULT_COUNT_WIDTH = 24;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_BOTH = 2'd2,
        EDGE_NONE = 2'd3
    } edge_mode_e;

    function automatic logic edge_trigger(edge_mode_e mode, logic rise, logic fall);
        logic trig;
        case (mode)
            EDGE_RISE: trig = rise;
            EDGE_FALL: trig = fall;
            EDGE_BOTH: trig = rise | fall;
            default:   trig = 1'b0;
        endcase
        return trig;
    endfunction

endpackage

// File: rtl/multi_pulse_stretcher_if.sv
// Channel bus of the pulse stretcher: async inputs, shared configuration,
// per-channel modes and the stretched/missed outputs.
interface multi_pulse_stretcher_if
    import multi_pulse_stretcher_pkg::*;
#(
    parameter int NCHAN       = 8,
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
);
    logic [NCHAN-1:0]       pulse_a;
    logic [COUNT_WIDTH-1:0] stretchTicks;
    logic [NCHAN-1:0]       retrigger;
    logic [1:0]             edgeMode;
    logic [NCHAN-1:0]       missedClear;
    logic [NCHAN-1:0]       pulseStretch;
    logic [NCHAN-1:0]       missed;

    modport master (
        output pulse_a, stretchTicks, retrigger, edgeMode, missedClear,
        input  pulseStretch, missed
    );

    modport slave (
        input  pulse_a, stretchTicks, retrigger, edgeMode, missedClear,
        output pulseStretch, missed
    );
endinterface

// File: rtl/multi_pulse_stretcher_channel.sv
// One stretcher channel: input capture, edge detect, stretch counter and
// sticky missed flag. MULTI_PULSE_STRETCHER_SYNC_EN selects a synchroniser chain.
module stretcher_channel
    import multi_pulse_stretcher_pkg::*;
#(
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pulse_a,
    input  logic [COUNT_WIDTH-1:0] stretch_ticks,
    input  logic                   retrigger,
    input  logic [1:0]             edge_mode,
    input  logic                   missed_clear,
    output logic                   pulse_stretch,
    output logic                   missed
);

    logic level;

`ifdef MULTI_PULSE_STRETCHER_SYNC_EN
    (* ASYNC_REG = "true" *) logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb sync_d = {sync_q[SYNC_STAGES-2:0], pulse_a};

    // NOTE: the capture stage is reset too, so no phantom edge appears after reset.
    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= sync_d;
    end

    assign level = sync_q[SYNC_STAGES-1];
`else
    localparam int unused_sync_stages = SYNC_STAGES;
    logic in_q, in_d;

    always_comb in_d = pulse_a;

    always_ff @(posedge clk) begin
        if (rst) in_q <= 1'b0;
        else     in_q <= in_d;
    end

    assign level = in_q;
`endif

    logic                   prev_q, prev_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   pulse_q, pulse_d;
    logic                   missed_q, missed_d;
    logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
    logic                   trigger, enabled, accept, ignore;

    // NOTE: combinational logic uses blocking '='; only always_ff uses '<='.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        prev_d      = level;
        rise_d      = level & ~prev_q;
        fall_d      = ~level & prev_q;
        pulse_d     = pulse_q;
        remaining_d = remaining_q;

        trigger = edge_trigger(edge_mode_e'(edge_mode), rise_q, fall_q);
        enabled = (stretch_ticks != '0) && (edge_mode_e'(edge_mode) != EDGE_NONE);
        accept  = trigger && enabled && (retrigger || !pulse_q);
        ignore  = trigger && enabled && !retrigger && pulse_q;

        // The shared length is captured only when a trigger is accepted.
        if (accept) begin
            pulse_d     = 1'b1;
            remaining_d = stretch_ticks - COUNT_WIDTH'(1);
        end else if (remaining_q != '0) begin
            remaining_d = remaining_q - COUNT_WIDTH'(1);
        end else begin
            pulse_d = 1'b0;
        end

        missed_d = ignore | (missed_q & ~missed_clear);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q      <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            pulse_q     <= 1'b0;
            missed_q    <= 1'b0;
            remaining_q <= '0;
        end else begin
            prev_q      <= prev_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            pulse_q     <= pulse_d;
            missed_q    <= missed_d;
            remaining_q <= remaining_d;
        end
    end

    assign pulse_stretch = pulse_q;
    assign missed        = missed_q;

endmodule

// File: rtl/multi_pulse_stretcher.sv
// NCHAN independent pulse stretchers sharing length and edge mode.
// Define MULTI_PULSE_STRETCHER_SYNC_EN to insert SYNC_STAGES-deep input synchronisers.
module multi_pulse_stretcher
    import multi_pulse_stretcher_pkg::*;
#(
    parameter int NCHAN       = 8,
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input logic                     clk,
    input logic                     rst,
    multi_pulse_stretcher_if.slave  bus
);

    logic [NCHAN-1:0] pulse_stretch;
    logic [NCHAN-1:0] missed;

    for (genvar i = 0; i < NCHAN; i++) begin : g_chan
        stretcher_channel #(
            .COUNT_WIDTH (COUNT_WIDTH),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk           (clk),
            .rst           (rst),
            .pulse_a       (bus.pulse_a[i]),
            .stretch_ticks (bus.stretchTicks),
            .retrigger     (bus.retrigger[i]),
            .edge_mode     (bus.edgeMode),
            .missed_clear  (bus.missedClear[i]),
            .pulse_stretch (pulse_stretch[i]),
            .missed        (missed[i])
        );
    end

    assign bus.pulseStretch = pulse_stretch;
    assign bus.missed       = missed;

endmodule

// File: tb/tb_multi_pulse_stretcher.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a deadline-based reference model of each channel.
module tb_multi_pulse_stretcher;

    localparam int NCHAN = 8;
    localparam int CW    = 24;
    localparam int SS    = 2;
    localparam int MAXC  = 8192;
`ifdef MULTI_PULSE_STRETCHER_SYNC_EN
    localparam int LAT = SS + 1;
`else
    localparam int LAT = 2;
`endif

    logic clk;
    logic rst;

    multi_pulse_stretcher_if #(.NCHAN(NCHAN), .COUNT_WIDTH(CW)) bus ();

    multi_pulse_stretcher #(
        .NCHAN       (NCHAN),
        .COUNT_WIDTH (CW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Reference model: input history per clock edge, and for each channel the
    // edge index at which its output must fall (high while edge < end_t).
    logic [NCHAN-1:0] hist [MAXC];
    int               end_t [NCHAN];
    logic [NCHAN-1:0] m_out    = '0;
    logic [NCHAN-1:0] m_missed = '0;
    int               k        = 0;
    int               rst_edge = -1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h edge=%0d", tag, got, exp, k);
        end
    endtask

    function automatic logic [NCHAN-1:0] get_s(input int j);
        if (j < 0 || j <= rst_edge || j >= MAXC) return '0;
        return hist[j];
    endfunction

    task automatic model_edge();
        logic [NCHAN-1:0] a, b;
        logic rise, fall, trig, en, was_high, ign;
        if (k < MAXC) hist[k] = bus.pulse_a;
        if (rst) begin
            rst_edge = k;
            for (int c = 0; c < NCHAN; c++) end_t[c] = 0;
            m_missed = '0;
        end else begin
            a  = get_s(k - LAT - 1);
            b  = get_s(k - LAT);
            en = (bus.stretchTicks != 0) && (bus.edgeMode != 2'd3);
            for (int c = 0; c < NCHAN; c++) begin
                rise = b[c] && !a[c];
                fall = a[c] && !b[c];
                case (bus.edgeMode)
                    2'd0:    trig = rise;
                    2'd1:    trig = fall;
                    2'd2:    trig = rise || fall;
                    default: trig = 1'b0;
                endcase
                was_high = (k - 1 < end_t[c]);
                ign = 1'b0;
                if (trig && en) begin
                    if (bus.retrigger[c] || !was_high) end_t[c] = k + int'(bus.stretchTicks);
                    else ign = 1'b1;
                end
                if (ign)                     m_missed[c] = 1'b1;
                else if (bus.missedClear[c]) m_missed[c] = 1'b0;
            end
        end
        for (int c = 0; c < NCHAN; c++) m_out[c] = (k < end_t[c]);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("pulseStretch", 64'(bus.pulseStretch), 64'(m_out));
        check("missed", 64'(bus.missed), 64'(m_missed));
        k++;
    endtask

    // Plays pat[i] on channel ch (and clrpat[i] on its clear strobe) for the
    // input applied before edge i; reports high count, output runs and first high edge.
    task automatic drive_pattern(input int ch, input logic [63:0] pat, input logic [63:0] clrpat,
                                 input int cycles, input int chg_at, input int chg_val,
                                 input int rst_at, output int hi, output int runs, output int first);
        logic o, prev_o;
        hi = 0; runs = 0; first = -1;
        prev_o = bus.pulseStretch[ch];
        for (int i = 0; i < cycles; i++) begin
            bus.pulse_a[ch]     = (i < 64) ? pat[i] : 1'b0;
            bus.missedClear[ch] = (i < 64) ? clrpat[i] : 1'b0;
            if (i == chg_at) bus.stretchTicks = CW'(chg_val);
            rst = (i == rst_at);
            step();
            o = bus.pulseStretch[ch];
            if (o) hi++;
            if (o && !prev_o) runs++;
            if (o && first < 0) first = i;
            prev_o = o;
        end
        bus.pulse_a[ch]     = 1'b0;
        bus.missedClear[ch] = 1'b0;
        rst = 1'b0;
    endtask

    int hi, runs, first;

    initial begin
        for (int c = 0; c < NCHAN; c++) end_t[c] = 0;
        rst = 1'b1;
        bus.pulse_a      = '0;
        bus.stretchTicks = '0;
        bus.retrigger    = '0;
        bus.edgeMode     = 2'd0;
        bus.missedClear  = '0;
        repeat (3) step();
        rst = 1'b0;
        repeat (3) step();

        // Rising edge, N=5, 4-cycle input on ch0.
        bus.stretchTicks = CW'(5);
        drive_pattern(0, 64'hF, 64'h0, 20, -1, 0, -1, hi, runs, first);
        check("rise_width", 64'(hi), 64'd5);
        check("rise_latency", 64'(first), 64'(LAT));

        // Retriggerable, N=10, edges at 0 and 6 on ch1.
        bus.stretchTicks = CW'(10);
        bus.retrigger    = NCHAN'(1 << 1);
        drive_pattern(1, 64'hC3, 64'h0, 40, -1, 0, -1, hi, runs, first);
        check("retrig_width", 64'(hi), 64'd16);
        check("retrig_runs", 64'(runs), 64'd1);
        check("retrig_missed", 64'(bus.missed[1]), 64'd0);

        // Non-retriggerable, same edges on ch2.
        bus.retrigger = '0;
        drive_pattern(2, 64'hC3, 64'h0, 40, -1, 0, -1, hi, runs, first);
        check("noretrig_width", 64'(hi), 64'd10);
        check("noretrig_missed", 64'(bus.missed[2]), 64'd1);
        // Clear strobe coincides with a freshly ignored edge: set wins.
        drive_pattern(2, 64'h33, 64'd1 << (4 + LAT), 40, -1, 0, -1, hi, runs, first);
        check("set_beats_clear", 64'(bus.missed[2]), 64'd1);
        drive_pattern(2, 64'h0, 64'h4, 6, -1, 0, -1, hi, runs, first);
        check("missed_cleared", 64'(bus.missed[2]), 64'd0);

        // Both edges, N=3, 20-cycle input on ch3.
        bus.edgeMode     = 2'd2;
        bus.stretchTicks = CW'(3);
        drive_pattern(3, 64'hFFFFF, 64'h0, 40, -1, 0, -1, hi, runs, first);
        check("both_width", 64'(hi), 64'd6);
        check("both_runs", 64'(runs), 64'd2);

        // Disabled by zero length, then by edge mode NONE.
        bus.stretchTicks = '0;
        drive_pattern(3, 64'h33, 64'h0, 20, -1, 0, -1, hi, runs, first);
        check("ticks0_width", 64'(hi), 64'd0);
        bus.stretchTicks = CW'(3);
        bus.edgeMode     = 2'd3;
        drive_pattern(3, 64'h33, 64'h0, 20, -1, 0, -1, hi, runs, first);
        check("none_width", 64'(hi), 64'd0);
        check("disabled_missed", 64'(bus.missed), 64'd0);

        // Length changes 8 -> 2 mid-stretch on ch4.
        bus.edgeMode     = 2'd0;
        bus.stretchTicks = CW'(8);
        drive_pattern(4, 64'hC003, 64'h0, 30, LAT + 3, 2, -1, hi, runs, first);
        check("chg_width", 64'(hi), 64'd10);
        check("chg_runs", 64'(runs), 64'd2);
        bus.stretchTicks = CW'(1);
        drive_pattern(4, 64'h33, 64'h0, 20, -1, 0, -1, hi, runs, first);
        check("n1_width", 64'(hi), 64'd2);
        check("n1_runs", 64'(runs), 64'd2);

        // Reset mid-stretch with missed set on ch5, then a fresh pulse.
        bus.stretchTicks = CW'(10);
        drive_pattern(5, 64'h33, 64'h0, 30, -1, 0, 8, hi, runs, first);
        check("rst_missed", 64'(bus.missed[5]), 64'd0);
        check("rst_out", 64'(bus.pulseStretch), 64'd0);
        drive_pattern(5, 64'h3, 64'h0, 20, -1, 0, -1, hi, runs, first);
        check("post_rst_width", 64'(hi), 64'd10);
        check("post_rst_latency", 64'(first), 64'(LAT));

        // Random traffic on all channels.
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NCHAN; c++)
                if ($urandom_range(5) == 0) bus.pulse_a[c] = ~bus.pulse_a[c];
            if ($urandom_range(40) == 0) bus.stretchTicks = CW'($urandom_range(12));
            if ($urandom_range(60) == 0)
                bus.edgeMode = ($urandom_range(9) == 0) ? 2'd3 : 2'($urandom_range(2));
            if ($urandom_range(30) == 0) bus.retrigger = NCHAN'($urandom);
            bus.missedClear = ($urandom_range(10) == 0) ? NCHAN'($urandom) : '0;
            rst = ($urandom_range(400) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_pulse_stretcher.md
# multi_pulse_stretcher

Multi-channel, runtime-programmable pulse stretcher, successor to the single-channel fixed-length stretcher. Each of NCHAN asynchronous inputs is synchronised, edge-detected per a selectable edge mode, and stretched to a run-time programmed number of clock cycles. Each channel has its own retrigger/no-retrigger mode. Non-retriggerable channels flag ignored pulses in a sticky `missed` bit. Sits between front-panel/trigger inputs and LED drivers or event-logic consumers.

## Interface
- `NCHAN`, 8, number of independent channels (1..32)
- `COUNT_WIDTH`, 24, width of stretch length and per-channel counter
- `SYNC_STAGES`, 2, synchroniser depth (≥2); used only when sync is compiled in
- `clk`  in  1  single clock; all logic on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `pulse_a`  in  NCHAN  asynchronous pulse inputs, one per channel
- `stretchTicks`  in  COUNT_WIDTH  stretch length in clk cycles, shared by all channels; 0 disables all channels
- `retrigger`  in  NCHAN  per-channel mode: 1 = retriggerable, 0 = pulses ignored while stretching
- `edgeMode`  in  2  0 = rising, 1 = falling, 2 = both, 3 = none (all channels disabled)
- `missedClear`  in  NCHAN  per-channel write-1-to-clear strobe for `missed`
- `pulseStretch`  out  NCHAN  registered stretched outputs
- `missed`  out  NCHAN  sticky: non-retriggerable channel ignored an edge

## Operation
- Reset: `pulseStretch`=0, `missed`=0, all counters 0, sync/edge registers 0. Reset mid-stretch drops the output on the next clock.
- Per channel, the input is synchronised, then compared with a one-cycle-delayed copy.
- A trigger is raised for one cycle when the selected edge occurs.
- Trigger accepted if `stretchTicks`≠0, `edgeMode`≠3, and either `retrigger`=1 or `pulseStretch`=0.
- Accepted trigger: `pulseStretch`←1 and remaining←`stretchTicks`−1. `stretchTicks` is sampled only at this moment; later changes do not affect an active stretch.
- No trigger, remaining≠0: remaining decrements; output stays 1.
- No trigger, remaining=0: `pulseStretch`←0.
- The output is therefore high for exactly N = sampled `stretchTicks` cycles. An `stretchTicks` of 1 gives a one-cycle output.
- Retriggerable: a new edge while high reloads remaining (including on the final high cycle). The output stays high N cycles after the last accepted edge, with no gap.
- Non-retriggerable: an edge while `pulseStretch`=1 is ignored and sets `missed`.
- Edges on disabled channels (`stretchTicks`=0 or `edgeMode`=3) are ignored and never set `missed`.
- `missed` clears on `missedClear`=1. Simultaneous set and clear: set wins.
- Counter arithmetic is unsigned COUNT_WIDTH bits. No wrap: decrement only when remaining≠0.

## Timing
- Latency from the first rising clk edge sampling `pulse_a` in the new state to `pulseStretch` high:
  - SYNC_STAGES+1 cycles with sync compiled in.
  - 2 cycles without.
- Input pulses must be held ≥ (SYNC_STAGES+1) clk periods to be detected; shorter pulses may be lost.
- Two edges of the same input closer than one clk period cannot be resolved (`edgeMode`=2 sees at most one trigger per cycle).
- `missed` asserts on the same clock edge the ignored trigger would have loaded the counter.
- `edgeMode`, `retrigger` and `missedClear` are used combinationally in the trigger cycle. They are not resynchronised and are assumed static or in the clk domain.

## Configuration
- `MULTI_PULSE_STRETCHER_SYNC_EN` defined:
  - Each input passes through a SYNC_STAGES-flop chain with `ASYNC_REG="true"`.
  - Latency is SYNC_STAGES+1.
- Not defined:
  - Inputs must already be in the clk domain.
  - A single input register replaces the chain, giving latency 2.
  - SYNC_STAGES is unused.
- All other behaviour is identical in both builds.

## Structure
- Package `multi_pulse_stretcher_pkg` holds:
  - edge-mode constants `EDGE_RISE`=2'd0, `EDGE_FALL`=2'd1, `EDGE_BOTH`=2'd2, `EDGE_NONE`=2'd3;
  - the default `COUNT_WIDTH`.
- Sub-module `stretcher_channel` holds one channel: sync/input register, edge detect, counter, output and missed flags. The top generates NCHAN instances sharing `stretchTicks`/`edgeMode`.

## Test plan
- Rising mode, `stretchTicks`=5: a 4-cycle pulse on ch0 gives `pulseStretch[0]` high exactly 5 cycles, starting SYNC_STAGES+1 cycles after the input rise; other channels stay 0.
- Retrigger=1, N=10: edges at t=0 and t=6 give the output high continuously for 16 cycles; `missed` stays 0.
- Retrigger=0, N=10: edges at t=0 and t=6 give the output high 10 cycles and `missed`=1. Asserting `missedClear` in the same cycle as a new ignored edge leaves `missed`=1.
- `edgeMode`=2, N=3: a 20-cycle input pulse gives two 3-cycle outputs, one at each edge. With `stretchTicks`=0 or `edgeMode`=3, there is no output and no `missed`.
- Change `stretchTicks` 8→2 mid-stretch: the current stretch still lasts 8 cycles and the next stretch lasts 2. N=1 gives single-cycle outputs.
- Assert `rst` mid-stretch with `missed`=1: all outputs are 0 on the next clock. A following pulse behaves as after power-up. Repeat the bench with `MULTI_PULSE_STRETCHER_SYNC_EN` undefined and check latency 2.
